// File: rtl/instr_cache_refill_ctrl.sv
// Instruction-cache refill controller: fetches a missing line beat by beat,
// installs its tag, and walks every set on a flush request.
module instr_cache_refill_ctrl #(
    parameter int unsigned PADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LINE_WORDS  = 8,
    parameter int unsigned NUM_SETS    = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_lookup_valid,
    input  logic [PADDR_WIDTH-1:0]        i_lookup_paddr,
    input  logic                          i_hit,
    input  logic                          i_flush,
    output logic                          o_stall,
    output logic                          o_mem_req_valid,
    input  logic                          i_mem_req_ready,
    output logic [PADDR_WIDTH-1:0]        o_mem_req_addr,
    input  logic                          i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]         i_mem_resp_data,
    output logic                          o_fill_we,
    output logic [$clog2(LINE_WORDS)-1:0] o_fill_idx,
    output logic [DATA_WIDTH-1:0]         o_fill_data,
    output logic                          o_tag_we,
    output logic [PADDR_WIDTH-1:0]        o_tag_paddr,
    output logic                          o_inv_we,
    output logic [$clog2(NUM_SETS)-1:0]   o_inv_idx,
    output logic                          o_refill_done
);

    localparam int unsigned OFFSET_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int unsigned IDX_W       = $clog2(LINE_WORDS);
    localparam int unsigned SET_W       = $clog2(NUM_SETS);
    localparam logic [PADDR_WIDTH-1:0] ALIGN_MASK = {PADDR_WIDTH{1'b1}} << OFFSET_BITS;

    typedef enum logic [2:0] {StIdle, StReq, StFill, StTag, StFlush} state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_beat_cnt;
    logic [SET_W-1:0]        r_inv_cnt;
    logic                    r_flush_pend;
    logic [PADDR_WIDTH-1:0]  r_addr;

    logic w_miss;
    logic w_last_beat;
    logic w_last_inv;

    assign w_miss      = i_lookup_valid & ~i_hit;
    assign w_last_beat = (r_beat_cnt == IDX_W'(LINE_WORDS - 1));
    assign w_last_inv  = (r_inv_cnt == SET_W'(NUM_SETS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_beat_cnt   <= '0;
            r_inv_cnt    <= '0;
            r_flush_pend <= 1'b0;
            r_addr       <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_flush) begin
                        r_state      <= StFlush;
                        r_flush_pend <= 1'b0;
                    end else if (w_miss) begin
                        r_state <= StReq;
                        r_addr  <= i_lookup_paddr & ALIGN_MASK;
                    end
                end
                StReq: begin
                    if (i_flush) r_flush_pend <= 1'b1;
                    if (i_mem_req_ready) begin
                        r_state    <= StFill;
                        r_beat_cnt <= '0;
                    end
                end
                StFill: begin
                    if (i_flush) r_flush_pend <= 1'b1;
                    if (i_mem_resp_valid) begin
                        // Power-of-two line length: the increment wraps to 0 on the last beat.
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_last_beat) r_state <= StTag;
                    end
                end
                StTag: begin
                    if (r_flush_pend || i_flush) begin
                        r_state      <= StFlush;
                        r_flush_pend <= 1'b0;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StFlush: begin
                    if (w_last_inv) begin
                        r_state   <= StIdle;
                        r_inv_cnt <= '0;
                    end else begin
                        r_inv_cnt <= r_inv_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Outputs decode the registered state; fill strobes pass the beat through in-cycle.
    always_comb begin
        o_stall         = 1'b1;
        o_mem_req_valid = 1'b0;
        o_mem_req_addr  = '0;
        o_fill_we       = 1'b0;
        o_fill_idx      = '0;
        o_fill_data     = '0;
        o_tag_we        = 1'b0;
        o_tag_paddr     = '0;
        o_inv_we        = 1'b0;
        o_inv_idx       = '0;
        o_refill_done   = 1'b0;
        case (r_state)
            StIdle: o_stall = w_miss;
            StReq: begin
                o_mem_req_valid = 1'b1;
                o_mem_req_addr  = r_addr;
            end
            StFill: begin
                if (i_mem_resp_valid) begin
                    o_fill_we   = 1'b1;
                    o_fill_idx  = r_beat_cnt;
                    o_fill_data = i_mem_resp_data;
                end
            end
            StTag: begin
                o_tag_we      = 1'b1;
                o_tag_paddr   = r_addr;
                o_refill_done = 1'b1;
            end
            StFlush: begin
                o_inv_we  = 1'b1;
                o_inv_idx = r_inv_cnt;
            end
            default: o_stall = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
// Bench for instr_cache_refill_ctrl: directed scenarios plus randomized refills,
// checked against transaction-level expectations computed here.
module tb_instr_cache_refill_ctrl;

    localparam int unsigned PADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned LINE_WORDS  = 8;
    localparam int unsigned NUM_SETS    = 4;
    localparam int unsigned LINE_BYTES  = LINE_WORDS * DATA_WIDTH / 8;

    logic                    i_clk;
    logic                    i_rst;
    logic                    i_lookup_valid;
    logic [PADDR_WIDTH-1:0]  i_lookup_paddr;
    logic                    i_hit;
    logic                    i_flush;
    logic                    o_stall;
    logic                    o_mem_req_valid;
    logic                    i_mem_req_ready;
    logic [PADDR_WIDTH-1:0]  o_mem_req_addr;
    logic                    i_mem_resp_valid;
    logic [DATA_WIDTH-1:0]   i_mem_resp_data;
    logic                    o_fill_we;
    logic [2:0]              o_fill_idx;
    logic [DATA_WIDTH-1:0]   o_fill_data;
    logic                    o_tag_we;
    logic [PADDR_WIDTH-1:0]  o_tag_paddr;
    logic                    o_inv_we;
    logic [1:0]              o_inv_idx;
    logic                    o_refill_done;

    int checks = 0;
    int errors = 0;

    instr_cache_refill_ctrl #(
        .PADDR_WIDTH (PADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .LINE_WORDS  (LINE_WORDS),
        .NUM_SETS    (NUM_SETS)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_lookup_valid   (i_lookup_valid),
        .i_lookup_paddr   (i_lookup_paddr),
        .i_hit            (i_hit),
        .i_flush          (i_flush),
        .o_stall          (o_stall),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_req_addr   (o_mem_req_addr),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_resp_data  (i_mem_resp_data),
        .o_fill_we        (o_fill_we),
        .o_fill_idx       (o_fill_idx),
        .o_fill_data      (o_fill_data),
        .o_tag_we         (o_tag_we),
        .o_tag_paddr      (o_tag_paddr),
        .o_inv_we         (o_inv_we),
        .o_inv_idx        (o_inv_idx),
        .o_refill_done    (o_refill_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge i_clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, {31'd0, o_mem_req_valid}, 0);
        chk({tag, "_addr"}, o_mem_req_addr, 0);
        chk({tag, "_fwe"}, {31'd0, o_fill_we}, 0);
        chk({tag, "_fidx"}, {29'd0, o_fill_idx}, 0);
        chk({tag, "_fdata"}, o_fill_data, 0);
        chk({tag, "_twe"}, {31'd0, o_tag_we}, 0);
        chk({tag, "_tpa"}, o_tag_paddr, 0);
        chk({tag, "_iwe"}, {31'd0, o_inv_we}, 0);
        chk({tag, "_iidx"}, {30'd0, o_inv_idx}, 0);
        chk({tag, "_done"}, {31'd0, o_refill_done}, 0);
    endtask

    // One full invalidate walk; a flush pulse at cycle ignore_at must have no effect.
    task automatic flush_seq(input int ignore_at);
        for (int k = 0; k < int'(NUM_SETS); k++) begin
            i_flush = (k == ignore_at);
            settle();
            chk("flush_iwe", {31'd0, o_inv_we}, 1);
            chk("flush_idx", {30'd0, o_inv_idx}, k);
            chk("flush_stall", {31'd0, o_stall}, 1);
            chk("flush_req", {31'd0, o_mem_req_valid}, 0);
            chk("flush_fwe", {31'd0, o_fill_we}, 0);
            tick();
        end
        i_flush = 1'b0;
    endtask

    // Drives a miss through to tag install; gap_mode 0 = back-to-back, 1 = alternate, 2 = random.
    task automatic refill(input logic [31:0] addr, input int ready_delay, input int gap_mode,
                          input bit seq_data, input int flush_a, input int flush_b,
                          input int abort_beat, output bit flush_seen);
        int n;
        int cyc;
        int f;
        logic [31:0] d;
        flush_seen = 1'b0;
        i_lookup_valid = 1'b1;
        i_hit = 1'b0;
        i_lookup_paddr = addr;
        i_flush = 1'b0;
        settle();
        chk("miss_stall", {31'd0, o_stall}, 1);
        chk("miss_noreq", {31'd0, o_mem_req_valid}, 0);
        tick();
        i_lookup_valid = 1'b0;
        i_lookup_paddr = $urandom;
        cyc = 0;
        for (int c = 0; c <= ready_delay; c++) begin
            i_mem_req_ready = (c == ready_delay);
            i_mem_resp_valid = 1'($urandom_range(0, 1));
            i_mem_resp_data = $urandom;
            i_flush = (cyc == flush_a || cyc == flush_b);
            if (i_flush) flush_seen = 1'b1;
            settle();
            chk("req_valid", {31'd0, o_mem_req_valid}, 1);
            chk("req_addr", o_mem_req_addr, line_of(addr));
            chk("req_stall", {31'd0, o_stall}, 1);
            chk("req_nofill", {31'd0, o_fill_we}, 0);
            tick();
            cyc++;
        end
        i_mem_req_ready = 1'b0;
        n = 0;
        f = 0;
        while (n < int'(LINE_WORDS)) begin
            if (f > 200) begin
                chk("fill_budget", n, LINE_WORDS);
                break;
            end
            case (gap_mode)
                0: i_mem_resp_valid = 1'b1;
                1: i_mem_resp_valid = (f % 2 == 0);
                default: i_mem_resp_valid = 1'($urandom_range(0, 1));
            endcase
            d = seq_data ? 32'hA0 + 32'(n) : $urandom;
            i_mem_resp_data = d;
            i_flush = (cyc == flush_a || cyc == flush_b);
            if (i_flush) flush_seen = 1'b1;
            if (i_mem_resp_valid && n == abort_beat) i_rst = 1'b1;
            settle();
            if (i_rst) begin
                chk("abort_stall", {31'd0, o_stall}, 0);
                chk_all_zero("abort");
                tick();
                i_rst = 1'b0;
                i_mem_resp_valid = 1'b0;
                i_flush = 1'b0;
                flush_seen = 1'b0;
                return;
            end
            if (i_mem_resp_valid) begin
                chk("fill_we", {31'd0, o_fill_we}, 1);
                chk("fill_idx", {29'd0, o_fill_idx}, n);
                chk("fill_data", o_fill_data, d);
                n++;
            end else begin
                chk("gap_we", {31'd0, o_fill_we}, 0);
                chk("gap_idx", {29'd0, o_fill_idx}, 0);
            end
            chk("fill_stall", {31'd0, o_stall}, 1);
            chk("fill_noreq", {31'd0, o_mem_req_valid}, 0);
            tick();
            cyc++;
            f++;
        end
        i_mem_resp_valid = 1'b0;
        i_flush = 1'b0;
        settle();
        chk("tag_we", {31'd0, o_tag_we}, 1);
        chk("tag_paddr", o_tag_paddr, line_of(addr));
        chk("tag_done", {31'd0, o_refill_done}, 1);
        chk("tag_stall", {31'd0, o_stall}, 1);
        chk("tag_nofill", {31'd0, o_fill_we}, 0);
        tick();
    endtask

    task automatic idle_quiet(input string tag);
        settle();
        chk({tag, "_stall"}, {31'd0, o_stall}, 0);
        chk({tag, "_req"}, {31'd0, o_mem_req_valid}, 0);
        chk({tag, "_iwe"}, {31'd0, o_inv_we}, 0);
        chk({tag, "_twe"}, {31'd0, o_tag_we}, 0);
        tick();
    endtask

    initial begin
        bit fs;
        logic [31:0] a;
        i_rst = 1'b1;
        i_lookup_valid = 1'b0;
        i_lookup_paddr = '0;
        i_hit = 1'b0;
        i_flush = 1'b0;
        i_mem_req_ready = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_mem_resp_data = '0;

        // Reset state; stall still tracks a miss presented in IDLE.
        settle();
        chk("rst_stall", {31'd0, o_stall}, 0);
        chk_all_zero("rst");
        i_lookup_valid = 1'b1;
        i_mem_resp_valid = 1'b1;
        #1;
        chk("rst_miss_stall", {31'd0, o_stall}, 1);
        chk("rst_nofill", {31'd0, o_fill_we}, 0);
        tick();
        i_lookup_valid = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_rst = 1'b0;
        idle_quiet("post_rst");

        // Basic refill with sequential data and immediate ready.
        refill(32'h0000_1234, 0, 0, 1'b1, -1, -1, -1, fs);
        idle_quiet("after_basic");

        // Delayed ready, alternating beats.
        refill($urandom, 3, 1, 1'b0, -1, -1, -1, fs);
        idle_quiet("after_gap");

        // Response beats in IDLE are ignored.
        i_mem_resp_valid = 1'b1;
        i_mem_resp_data = $urandom;
        settle();
        chk("idle_resp_nofill", {31'd0, o_fill_we}, 0);
        tick();
        i_mem_resp_valid = 1'b0;

        // Flush and miss together: flush first, then the still-presented miss.
        a = $urandom;
        i_flush = 1'b1;
        i_lookup_valid = 1'b1;
        i_hit = 1'b0;
        i_lookup_paddr = a;
        settle();
        chk("fm_stall", {31'd0, o_stall}, 1);
        chk("fm_noreq", {31'd0, o_mem_req_valid}, 0);
        chk("fm_noinv", {31'd0, o_inv_we}, 0);
        tick();
        i_flush = 1'b0;
        flush_seq(-1);
        refill(a, 1, 0, 1'b0, -1, -1, -1, fs);
        idle_quiet("after_fm");

        // Two flush pulses during FILL collapse into one walk right after TAG.
        refill($urandom, 0, 0, 1'b0, 3, 6, -1, fs);
        chk("two_flush_seen", {31'd0, fs}, 1);
        flush_seq(2);
        idle_quiet("after_two_flush");

        // Reset at beat 4 aborts; a hit afterwards must not stall or request.
        refill($urandom, 0, 0, 1'b0, 2, -1, 4, fs);
        i_lookup_valid = 1'b1;
        i_hit = 1'b1;
        i_mem_resp_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("post_abort_stall", {31'd0, o_stall}, 0);
            chk("post_abort_req", {31'd0, o_mem_req_valid}, 0);
            chk("post_abort_fwe", {31'd0, o_fill_we}, 0);
            chk("post_abort_iwe", {31'd0, o_inv_we}, 0);
            tick();
        end
        i_lookup_valid = 1'b0;
        i_hit = 1'b0;
        i_mem_resp_valid = 1'b0;

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    i_lookup_valid = 1'b1;
                    i_hit = 1'b1;
                    i_lookup_paddr = $urandom;
                    i_mem_resp_valid = 1'($urandom_range(0, 1));
                    settle();
                    chk("rnd_hit_stall", {31'd0, o_stall}, 0);
                    chk("rnd_hit_fwe", {31'd0, o_fill_we}, 0);
                    tick();
                    i_lookup_valid = 1'b0;
                    i_hit = 1'b0;
                    i_mem_resp_valid = 1'b0;
                    idle_quiet("rnd_hit_after");
                end
                1: begin
                    i_flush = 1'b1;
                    settle();
                    chk("rnd_fl_noinv", {31'd0, o_inv_we}, 0);
                    tick();
                    i_flush = 1'b0;
                    flush_seq(int'($urandom_range(0, 4)));
                    idle_quiet("rnd_fl_after");
                end
                default: begin
                    refill($urandom, int'($urandom_range(0, 3)), 2, 1'b0,
                           ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1,
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1,
                           -1, fs);
                    if (fs) flush_seq(int'($urandom_range(0, 4)));
                    idle_quiet("rnd_rf_after");
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
